// File: rtl/score_display_unit.sv
// Line-clear scorer with saturating BCD score and serial 7-segment frame streamer.
// Build option: define LEADING_ZERO_BLANK_EN to blank score digits left of the most significant nonzero digit.
module score_display_unit #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned LINE_W  = 3,
  parameter int unsigned PTS1    = 1,
  parameter int unsigned PTS2    = 3,
  parameter int unsigned PTS3    = 5,
  parameter int unsigned PTS4    = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hit,
  input  logic [LINE_W-1:0]     line_count,
  input  logic                  clr_score,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  sat,
  output logic                  SEGCLK,
  output logic                  SEGCLR,
  output logic                  SEGDT,
  output logic                  SEGEN
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  // ---------------- scoring ----------------
  logic [4*DIGITS-1:0] r_score;
  logic [3:0]          r_pending;
  logic                r_sat;

  logic [31:0]         w_lc;
  logic [3:0]          w_pts;
  logic                w_dec;
  logic [4:0]          w_sum;
  logic [3:0]          w_pending_next;
  logic [4*DIGITS-1:0] w_score_inc;
  logic                w_all9;

  assign w_lc = 32'(line_count);

  always_comb begin
    w_pts = '0;
    if (w_lc >= 32'd4) begin
      w_pts = 4'(PTS4);
    end else begin
      case (w_lc)
        32'd1:   w_pts = 4'(PTS1);
        32'd2:   w_pts = 4'(PTS2);
        32'd3:   w_pts = 4'(PTS3);
        default: w_pts = '0;
      endcase
    end
  end

  assign w_dec          = (r_pending != '0);
  assign w_sum          = {1'b0, r_pending} - {4'b0, w_dec} + (hit ? {1'b0, w_pts} : 5'd0);
  assign w_pending_next = (w_sum > 5'd15) ? 4'hF : w_sum[3:0];

  // Decimal ripple increment; w_all9 marks the saturation point.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    carry       = 1'b1;
    d           = '0;
    w_all9      = 1'b1;
    w_score_inc = r_score;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = r_score[4*i +: 4];
      if (d != 4'd9) w_all9 = 1'b0;
      if (carry) begin
        if (d == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;
        end else begin
          w_score_inc[4*i +: 4] = d + 4'd1;
          carry                 = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score   <= '0;
      r_pending <= '0;
      r_sat     <= 1'b0;
    end else if (clr_score) begin
      r_score   <= '0;
      r_pending <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (w_dec && !r_sat) begin
        if (w_all9) r_sat   <= 1'b1;
        else        r_score <= w_score_inc;
      end
    end
  end

  assign busy      = (r_pending != '0);
  assign score_bcd = r_score;
  assign sat       = r_sat;

  // ---------------- frame build ----------------
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  logic [63:0] w_frame;

  // Positions are walked from the left so leading-zero state can propagate rightwards.
  always_comb begin
    logic [31:0] pad;
    logic [3:0]  d;
    int unsigned p;
`ifdef LEADING_ZERO_BLANK_EN
    logic        lead;
    lead = 1'b1;
`endif
    pad     = 32'(r_score);
    d       = '0;
    p       = 0;
    w_frame = '1;
    for (int unsigned k = 0; k < 8; k++) begin
      p = 7 - k;
      if (p < DIGITS) begin
        d = pad[4*p +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (lead && (d == 4'd0) && (p != 0)) begin
          w_frame[8*p +: 8] = 8'hFF;
        end else begin
          lead              = 1'b0;
          w_frame[8*p +: 8] = seg7(d);
        end
`else
        w_frame[8*p +: 8] = seg7(d);
`endif
      end
    end
  end

  // ---------------- serialiser ----------------
  state_t           r_state;
  state_t           w_state_next;
  logic [63:0]      r_frame;
  logic [6:0]       r_bitcnt;
  logic [DIV_W-1:0] r_divcnt;
  logic             r_phase;
  logic             r_segclk;
  logic             r_segdt;
  logic             r_segclr;
  logic             r_segen;

  logic             w_div_done;
  logic             w_last_bit;

  assign w_div_done = (r_divcnt == DIV_W'(CLK_DIV - 1));
  assign w_last_bit = (r_bitcnt == 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_LOAD;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD:  w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_div_done && r_phase && w_last_bit) w_state_next = ST_GAP;
      ST_GAP:   if (w_div_done) w_state_next = ST_LOAD;
      default:  w_state_next = ST_LOAD;
    endcase
  end

  // r_frame[63] always holds the bit currently on SEGDT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame  <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
      r_phase  <= 1'b0;
      r_segclk <= 1'b0;
      r_segdt  <= 1'b0;
      r_segclr <= 1'b0;
      r_segen  <= 1'b0;
    end else begin
      r_segclr <= 1'b1;
      r_segen  <= 1'b1;
      case (r_state)
        ST_LOAD: begin
          r_frame  <= w_frame;
          r_bitcnt <= 7'd64;
          r_divcnt <= '0;
          r_phase  <= 1'b0;
          r_segclk <= 1'b0;
          r_segdt  <= w_frame[63];
        end
        ST_SHIFT: begin
          if (!w_div_done) begin
            r_divcnt <= r_divcnt + 1'b1;
          end else begin
            r_divcnt <= '0;
            if (!r_phase) begin
              r_phase  <= 1'b1;
              r_segclk <= 1'b1;
            end else begin
              r_phase  <= 1'b0;
              r_segclk <= 1'b0;
              r_bitcnt <= r_bitcnt - 7'd1;
              if (!w_last_bit) begin
                r_frame <= {r_frame[62:0], 1'b0};
                r_segdt <= r_frame[62];
              end
            end
          end
        end
        ST_GAP: begin
          r_segclk <= 1'b0;
          r_divcnt <= w_div_done ? '0 : r_divcnt + 1'b1;
        end
        default: r_divcnt <= '0;
      endcase
    end
  end

  assign SEGCLK = r_segclk;
  assign SEGDT  = r_segdt;
  assign SEGCLR = r_segclr;
  assign SEGEN  = r_segen;

endmodule
